traffic_lights_cmd_gen: RTL and testbench

Command initiator for the traffic-light controller's command port (cmd_type/cmd_valid/cmd_data). It accepts one configuration request through a valid/ready handshake. It then serialises the request into single-cycle command writes: timing updates first (green, red, yellow, in that order), then one mode command. It sits between the host/CSR logic and the traffic-light controller.

---
 rtl/traffic_lights_cmd_gen.sv | 148 ++++++++++++++
 tb/tb_traffic_lights_cmd_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_cmd_gen.sv
// traffic_lights_cmd_gen
// Takes one configuration request over a valid/ready handshake and turns it
// into a series of single-cycle command writes to the traffic-light
// controller. The timing updates go out first (green, red, yellow), followed
// by an optional mode command.
//
// Ports
//   clk_i, rst_n_i        clock; asynchronous active-low reset
//   req_valid_i/ready_o   request handshake (ready only in IDLE)
//   req_mode_i            0 normal, 1 off, 2 yellow-blink, 3 no mode change
//   req_mask_i            bit0 green, bit1 red, bit2 yellow timing update
//   req_*_ms_i            timing values in ms
//   cmd_valid_o/type/data one-cycle command strobe; type/data are 0 when idle
//   busy_o                high from accept through the done cycle
//   done_o                one-cycle pulse after the last command
module traffic_lights_cmd_gen #(
  parameter int CMD_GAP = 2,
  parameter int MIN_MS  = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_mode_i,
  input  logic [2:0]  req_mask_i,
  input  logic [15:0] req_green_ms_i,
  input  logic [15:0] req_red_ms_i,
  input  logic [15:0] req_yellow_ms_i,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_type_o,
  output logic [15:0] cmd_data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int GW = (CMD_GAP > 1) ? $clog2(CMD_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic          rdy_q;
  logic [2:0]    mask_q;
  logic [1:0]    mode_q;
  logic [15:0]   green_q, red_q, yellow_q;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic [2:0]    first_req, next_q;

  // Command slots: 0 green, 1 red, 2 yellow, 3 mode. Returns {found, slot}
  // for the lowest enabled slot at or above start.
  function automatic logic [2:0] first_from(input logic [3:0] en, input logic [2:0] start);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (en[i] && (3'(i) >= start)) r = {1'b1, 2'(i)};
    return r;
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] ms);
    return (ms < 16'(MIN_MS)) ? 16'(MIN_MS) : ms;
  endfunction

  assign accept    = req_valid_i & rdy_q;
  assign first_req = first_from({req_mode_i != 2'd3, req_mask_i}, 3'd0);
  assign next_q    = first_from({mode_q != 2'd3, mask_q}, {1'b0, idx_q} + 3'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d = '0;
        if (first_req[2]) begin
          state_d = ISSUE;
          idx_d   = first_req[1:0];
        end else begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (!next_q[2]) state_d = DONE;  // last command: no trailing gap
        else begin
          idx_d   = next_q[1:0];
          state_d = (CMD_GAP == 0) ? ISSUE : GAP;
        end
      end
      GAP: begin
        if (cnt_q == GW'(CMD_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;  // DONE
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      green_q  <= '0;
      red_q    <= '0;
      yellow_q <= '0;
    end else begin
      state_q <= state_d;
      // Registered so ready stays low during reset and rises on the first edge.
      rdy_q   <= (state_d == IDLE);
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mask_q   <= req_mask_i;
        mode_q   <= req_mode_i;
        green_q  <= req_green_ms_i;
        red_q    <= req_red_ms_i;
        yellow_q <= req_yellow_ms_i;
      end
    end
  end

  always_comb begin
    cmd_type_o = '0;
    cmd_data_o = '0;
    if (state_q == ISSUE) begin
      case (idx_q)
        2'd0:    begin cmd_type_o = 3'd3; cmd_data_o = clamp(green_q);  end
        2'd1:    begin cmd_type_o = 3'd4; cmd_data_o = clamp(red_q);    end
        2'd2:    begin cmd_type_o = 3'd5; cmd_data_o = clamp(yellow_q); end
        default: cmd_type_o = {1'b0, mode_q};
      endcase
    end
  end

  assign cmd_valid_o = (state_q == ISSUE);
  assign req_ready_o = rdy_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_traffic_lights_cmd_gen.sv
// Testbench for traffic_lights_cmd_gen. It drives two instances, one with
// CMD_GAP=2 (sel=0) and one with CMD_GAP=0 (sel=1). The expected per-cycle
// output trace is built from the request by a list-based model.
module tb_traffic_lights_cmd_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv2 = 1'b0, rv0 = 1'b0;
  logic [1:0]  mode = '0;
  logic [2:0]  mask = '0;
  logic [15:0] gms = '0, rms = '0, yms = '0;
  logic        sel = 1'b0;

  logic        cv2, cv0, rd2, rd0, b2, b0, d2, d0;
  logic [2:0]  ct2, ct0;
  logic [15:0] cd2, cd0;
  logic [22:0] obs;          // {valid, type, data, busy, done, ready}
  logic [22:0] exp_t [64];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  traffic_lights_cmd_gen #(.CMD_GAP(2), .MIN_MS(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(rv2), .req_ready_o(rd2),
    .req_mode_i(mode), .req_mask_i(mask), .req_green_ms_i(gms),
    .req_red_ms_i(rms), .req_yellow_ms_i(yms), .cmd_valid_o(cv2),
    .cmd_type_o(ct2), .cmd_data_o(cd2), .busy_o(b2), .done_o(d2));

  traffic_lights_cmd_gen #(.CMD_GAP(0), .MIN_MS(1)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(rv0), .req_ready_o(rd0),
    .req_mode_i(mode), .req_mask_i(mask), .req_green_ms_i(gms),
    .req_red_ms_i(rms), .req_yellow_ms_i(yms), .cmd_valid_o(cv0),
    .cmd_type_o(ct0), .cmd_data_o(cd0), .busy_o(b0), .done_o(d0));

  assign obs = sel ? {cv0, ct0, cd0, b0, d0, rd0} : {cv2, ct2, cd2, b2, d2, rd2};

  // Reference model: expand the request into a command list. Command k is
  // placed at cycle 1 + k*(gap+1), done follows the last command (or cycle 1
  // when the list is empty), and ready returns the cycle after done.
  task automatic build_exp(input int gap, input logic [2:0] m, input logic [1:0] md,
                           input logic [15:0] g, input logic [15:0] r,
                           input logic [15:0] y, output int len);
    int t_q[$];
    int d_q[$];
    int ms[3];
    int n, dc;
    ms[0] = g; ms[1] = r; ms[2] = y;
    for (int i = 0; i < 3; i++)
      if (m[i]) begin t_q.push_back(3 + i); d_q.push_back(ms[i] < 1 ? 1 : ms[i]); end
    if (md != 2'd3) begin t_q.push_back(md); d_q.push_back(0); end
    n   = t_q.size();
    dc  = (n == 0) ? 1 : (n - 1) * (gap + 1) + 2;
    len = dc + 1;
    for (int c = 1; c <= len; c++)
      exp_t[c] = {1'b0, 3'd0, 16'd0, c <= dc, c == dc, c == len};
    for (int k = 0; k < n; k++)
      exp_t[1 + k * (gap + 1)] = {1'b1, 3'(t_q[k]), 16'(d_q[k]), 1'b1, 1'b0, 1'b0};
  endtask

  task automatic set_req(input logic [2:0] m, input logic [1:0] md,
                         input logic [15:0] g, input logic [15:0] r, input logic [15:0] y);
    mask = m; mode = md; gms = g; rms = r; yms = y;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50 && !obs[0]; i++) @(negedge clk);
    total++;
    if (!obs[0]) begin bad++; $display("FAIL %s ready timeout got=%b want=1", name, obs[0]); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rv2 = 1'b0; rv0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sel = s[0]; #0;
        total++;
        if (obs !== 23'h0) begin bad++; $display("FAIL reset_hold sel=%0d got=%h want=0", s, obs); end
      end
    end
    sel = 1'b0;
    rst_n = 1'b1; #1;
    total++;
    if (obs !== 23'h0) begin bad++; $display("FAIL reset_release got=%h want=0", obs); end
    @(negedge clk);
    total++;
    if (obs !== 23'h1) begin bad++; $display("FAIL reset_ready got=%h want=1", obs); end
  endtask

  // Drives one request on the selected instance and compares its trace.
  task automatic test_seq(input string name, input logic s, input logic [2:0] m,
                          input logic [1:0] md, input logic [15:0] g,
                          input logic [15:0] r, input logic [15:0] y);
    int len;
    sel = s;
    wait_ready(name);
    set_req(m, md, g, r, y);
    build_exp(s ? 0 : 2, m, md, g, r, y, len);
    if (s) rv0 = 1'b1; else rv2 = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      rv0 = 1'b0; rv2 = 1'b0;
      total++;
      if (obs !== exp_t[c]) begin
        bad++; $display("FAIL %s cyc=%0d got=%h want=%h", name, c, obs, exp_t[c]);
      end
    end
  endtask

  task automatic test_full();
    test_seq("full", 1'b0, 3'b111, 2'd0, 16'd5000, 16'd3000, 16'd1000);
  endtask

  task automatic test_clamp();
    test_seq("clamp", 1'b0, 3'b010, 2'd3, 16'd7, 16'd0, 16'd9);
  endtask

  task automatic test_empty();
    test_seq("empty_g2", 1'b0, 3'b000, 2'd3, 16'd1, 16'd2, 16'd3);
    test_seq("empty_g0", 1'b1, 3'b000, 2'd3, 16'd1, 16'd2, 16'd3);
  endtask

  // Valid stays high across the first request; the second request must be
  // accepted on the first ready cycle and the first one's inputs ignored while busy.
  task automatic test_back_to_back();
    int la, lb;
    logic [15:0] g, y;
    sel = 1'b1;
    wait_ready("b2b");
    g = 16'($urandom); y = 16'($urandom_range(0, 3));
    set_req(3'b101, 2'd2, g, 16'd55, y);
    build_exp(0, 3'b101, 2'd2, g, 16'd55, y, la);
    rv0 = 1'b1;
    for (int c = 1; c <= la; c++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_t[c]) begin bad++; $display("FAIL b2b_a cyc=%0d got=%h want=%h", c, obs, exp_t[c]); end
      if (c == 1) set_req(3'b110, 2'd1, 16'd9, 16'd0, 16'd4);  // ignored while busy
      if (c == la) set_req(3'b011, 2'd0, 16'd0, 16'd250, 16'd4);
    end
    build_exp(0, 3'b011, 2'd0, 16'd0, 16'd250, 16'd4, lb);
    for (int c = 1; c <= lb; c++) begin
      @(negedge clk);
      rv0 = 1'b0;
      total++;
      if (obs !== exp_t[c]) begin bad++; $display("FAIL b2b_b cyc=%0d got=%h want=%h", c, obs, exp_t[c]); end
    end
  endtask

  task automatic test_random();
    int len;
    logic [15:0] g, r, y;
    logic [2:0] m;
    logic [1:0] md;
    for (int it = 0; it < 24; it++) begin
      sel = 1'($urandom);
      m   = 3'($urandom);
      md  = 2'($urandom);
      g   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      r   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      y   = ($urandom_range(0, 3) == 0) ? 16'd1 : 16'($urandom);
      wait_ready("rand");
      set_req(m, md, g, r, y);
      build_exp(sel ? 0 : 2, m, md, g, r, y, len);
      if (sel) rv0 = 1'b1; else rv2 = 1'b1;
      for (int c = 1; c <= len; c++) begin
        @(negedge clk);
        rv0 = 1'b0; rv2 = 1'b0;
        total++;
        if (obs !== exp_t[c]) begin
          bad++; $display("FAIL rand it=%0d cyc=%0d got=%h want=%h", it, c, obs, exp_t[c]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int len;
    sel = 1'b0;
    wait_ready("arst");
    set_req(3'b111, 2'd0, 16'd5000, 16'd3000, 16'd1000);
    build_exp(2, 3'b111, 2'd0, 16'd5000, 16'd3000, 16'd1000, len);
    rv2 = 1'b1;
    for (int c = 1; c <= 5; c++) begin  // strobes at 1 and 4, then into the gap
      @(negedge clk);
      rv2 = 1'b0;
      total++;
      if (obs !== exp_t[c]) begin bad++; $display("FAIL arst_pre cyc=%0d got=%h want=%h", c, obs, exp_t[c]); end
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 23'h0) begin bad++; $display("FAIL arst_now got=%h want=0", obs); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 23'h0) begin bad++; $display("FAIL arst_hold got=%h want=0", obs); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 23'h1) begin bad++; $display("FAIL arst_after cyc=%0d got=%h want=1", c, obs); end
    end
    test_seq("arst_new", 1'b0, 3'b111, 2'd1, 16'd12, 16'd0, 16'd300);
  endtask

  initial begin
    test_reset();
    test_full();
    test_clamp();
    test_empty();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
